// File: rtl/lb_idle_buf_pkg.sv
// Shared PCS block definitions for the idle buffer: block layout, fixed idle/error
// encodings and the frame-tracking rule used on both sides of the FIFO.
package lb_idle_buf_pkg;

  localparam int DATA_W      = 64;
  localparam int KEEP_W      = 8;
  localparam int START_MAX_W = 2;

  // One start bit per lane position: two in 10G mode, one otherwise.
  function automatic int start_w(input int is_10g);
    return (is_10g != 0) ? 2 : 1;
  endfunction

  typedef struct packed {
    logic                   ctrl;
    logic                   idle;
    logic [START_MAX_W-1:0] start;
    logic                   term;
    logic                   err;
    logic [DATA_W-1:0]      data;
    logic [KEEP_W-1:0]      keep;
  } pcs_blk_t;

  localparam int BLK_W = $bits(pcs_blk_t);

  localparam pcs_blk_t IDLE_BLK = '{ctrl: 1'b1, idle: 1'b1, start: '0, term: 1'b0,
                                    err: 1'b0, data: '0, keep: '0};
  localparam pcs_blk_t ERR_BLK  = '{ctrl: 1'b1, idle: 1'b0, start: '0, term: 1'b0,
                                    err: 1'b1, data: '0, keep: '0};

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  // Frame enters on any start, leaves on terminate or on an error block.
  function automatic logic [0:0] frame_next(input logic [0:0] st, input logic vld,
                                            input logic sop, input logic eop,
                                            input logic err);
    frame_next = st;
    if (st == ST_IDLE) begin
      if (vld && sop) frame_next = ST_FRAME;
    end else if ((vld && eop) || err) begin
      frame_next = ST_IDLE;
    end
  endfunction

endpackage

// File: rtl/lb_idle_buf_fifo.sv
// Synchronous FIFO of PCS blocks with a level counter; a push onto a full FIFO
// succeeds when a pop happens in the same cycle.
module lb_idle_buf_fifo
  import lb_idle_buf_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [BLK_W-1:0] din_i,
  output logic [BLK_W-1:0] dout_o,
  output logic [LW-1:0]    level_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [BLK_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/lb_idle_buf.sv
// Rate-matching idle buffer between PCS RX and TX: deletes idles between frames when
// nearly full, inserts idles (or an error block mid-frame) when empty.
// Define LB_IDLE_BUF_STAT_EN to build the saturating deleted/inserted idle counters.
module lb_idle_buf
  import lb_idle_buf_pkg::*;
#(
  parameter int IS_10G = 1,
  parameter int DEPTH  = 8,
  parameter int HI_WM  = DEPTH - 2,
  localparam int START_W = start_w(IS_10G)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic               ctrl_v_i,
  input  logic               idle_v_i,
  input  logic [START_W-1:0] start_v_i,
  input  logic               term_v_i,
  input  logic               err_v_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [KEEP_W-1:0]  keep_i,
  input  logic               ready_i,
  output logic               ctrl_v_o,
  output logic               idle_v_o,
  output logic [START_W-1:0] start_v_o,
  output logic               term_v_o,
  output logic               err_v_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [KEEP_W-1:0]  keep_o,
  output logic [1:0]         sticky_o,
  output logic [15:0]        del_cnt_o,
  output logic [15:0]        ins_cnt_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] HI_WM_L = LW'(HI_WM);

  pcs_blk_t   in_blk, head_blk, out_q, out_d;
  logic [LW-1:0] level;
  logic       empty, full;
  logic [0:0] w_state_q, w_state_d, r_state_q, r_state_d;
  logic [1:0] sticky_q, sticky_d;
  logic       del_blk, push, pop, ovf;

  assign in_blk = '{ctrl: ctrl_v_i, idle: idle_v_i, start: START_MAX_W'(start_v_i),
                    term: term_v_i, err: err_v_i, data: data_i, keep: keep_i};

  // Idles are only safe to drop between frames.
  assign del_blk = valid_i && idle_v_i && (w_state_q == ST_IDLE) && (level >= HI_WM_L);
  assign push    = valid_i && !del_blk;
  assign pop     = ready_i && !empty;
  assign ovf     = push && full && !pop;

  lb_idle_buf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (ready_i),
    .din_i   (in_blk),
    .dout_o  (head_blk),
    .level_o (level),
    .empty_o (empty),
    .full_o  (full)
  );

  always_comb begin
    w_state_d = frame_next(w_state_q, valid_i, |start_v_i, term_v_i, err_v_i);
    r_state_d = r_state_q;
    out_d     = out_q;
    sticky_d  = sticky_q;
    if (ovf) sticky_d[0] = 1'b1;
    if (ready_i) begin
      if (!empty) begin
        out_d     = head_blk;
        r_state_d = frame_next(r_state_q, 1'b1, |head_blk.start, head_blk.term, head_blk.err);
      end else if (r_state_q == ST_IDLE) begin
        out_d = IDLE_BLK;
      end else begin
        // Ran dry inside a frame: poison it so the far end discards it.
        out_d       = ERR_BLK;
        sticky_d[1] = 1'b1;
        r_state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= ST_IDLE;
      r_state_q <= ST_IDLE;
      sticky_q  <= '0;
      out_q     <= IDLE_BLK;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      sticky_q  <= sticky_d;
      out_q     <= out_d;
    end
  end

  assign ctrl_v_o  = out_q.ctrl;
  assign idle_v_o  = out_q.idle;
  assign start_v_o = out_q.start[START_W-1:0];
  assign term_v_o  = out_q.term;
  assign err_v_o   = out_q.err;
  assign data_o    = out_q.data;
  assign keep_o    = out_q.keep;
  assign sticky_o  = sticky_q;

`ifdef LB_IDLE_BUF_STAT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] del_cnt_q, ins_cnt_q;
  logic        ins_idle;

  assign ins_idle = ready_i && empty && (r_state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      del_cnt_q <= '0;
      ins_cnt_q <= '0;
    end else begin
      if (del_blk)  del_cnt_q <= sat_inc16(del_cnt_q);
      if (ins_idle) ins_cnt_q <= sat_inc16(ins_cnt_q);
    end
  end

  assign del_cnt_o = del_cnt_q;
  assign ins_cnt_o = ins_cnt_q;
`else
  assign del_cnt_o = '0;
  assign ins_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lb_idle_buf.sv
// Directed bench for lb_idle_buf (DEPTH=8, 10G mode): stream, deletion, insertion,
// underrun, overflow/hold and mid-frame reset scenarios.
module tb_lb_idle_buf;

  typedef logic [77:0] vec_t;

`ifdef LB_IDLE_BUF_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, valid_i, ctrl_v_i, idle_v_i, term_v_i, err_v_i, ready_i;
  logic [1:0]  start_v_i;
  logic [63:0] data_i;
  logic [7:0]  keep_i;
  logic        ctrl_v_o, idle_v_o, term_v_o, err_v_o;
  logic [1:0]  start_v_o;
  logic [63:0] data_o;
  logic [7:0]  keep_o;
  logic [1:0]  sticky_o;
  logic [15:0] del_cnt_o, ins_cnt_o;

  int tests = 0;
  int fails = 0;

  vec_t out_vec;
  assign out_vec = {ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, data_o, keep_o};

  always #5 clk = ~clk;

  lb_idle_buf dut (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (valid_i),
    .ctrl_v_i  (ctrl_v_i),
    .idle_v_i  (idle_v_i),
    .start_v_i (start_v_i),
    .term_v_i  (term_v_i),
    .err_v_i   (err_v_i),
    .data_i    (data_i),
    .keep_i    (keep_i),
    .ready_i   (ready_i),
    .ctrl_v_o  (ctrl_v_o),
    .idle_v_o  (idle_v_o),
    .start_v_o (start_v_o),
    .term_v_o  (term_v_o),
    .err_v_o   (err_v_o),
    .data_o    (data_o),
    .keep_o    (keep_o),
    .sticky_o  (sticky_o),
    .del_cnt_o (del_cnt_o),
    .ins_cnt_o (ins_cnt_o)
  );

  localparam vec_t IDLE_V = {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 64'd0, 8'h00};
  localparam vec_t ERR_V  = {1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 64'd0, 8'h00};

  function automatic vec_t data_v(input logic [63:0] d);
    return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, d, 8'hFF};
  endfunction
  function automatic vec_t start_v(input logic [63:0] d);
    return {1'b1, 1'b0, 2'b01, 1'b0, 1'b0, d, 8'hFE};
  endfunction
  function automatic vec_t term_v(input logic [63:0] d);
    return {1'b1, 1'b0, 2'b00, 1'b1, 1'b0, d, 8'h0F};
  endfunction
  function automatic logic [63:0] sdat(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction
  function automatic vec_t stream_v(input int i);
    if (i == 0)  return start_v(sdat(i));
    if (i == 19) return term_v(sdat(i));
    return data_v(sdat(i));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_none();
    valid_i = 0; ctrl_v_i = 0; idle_v_i = 0; start_v_i = 2'b00;
    term_v_i = 0; err_v_i = 0; data_i = '0; keep_i = '0;
  endtask
  task automatic drive_data(input logic [63:0] d);
    drive_none(); valid_i = 1; data_i = d; keep_i = 8'hFF;
  endtask
  task automatic drive_start(input logic [63:0] d);
    drive_none(); valid_i = 1; ctrl_v_i = 1; start_v_i = 2'b01; data_i = d; keep_i = 8'hFE;
  endtask
  task automatic drive_term(input logic [63:0] d);
    drive_none(); valid_i = 1; ctrl_v_i = 1; term_v_i = 1; data_i = d; keep_i = 8'h0F;
  endtask
  task automatic drive_idle();
    drive_none(); valid_i = 1; ctrl_v_i = 1; idle_v_i = 1;
  endtask
  task automatic do_reset();
    reset = 1; ready_i = 0; drive_none();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; ready_i = 1; drive_none();
    tick();
    tests++; if (out_vec !== IDLE_V) begin fails++; $display("FAIL reset_out got=%h exp=%h", out_vec, IDLE_V); end
    tests++; if (sticky_o !== 2'b00) begin fails++; $display("FAIL reset_sticky got=%b exp=00", sticky_o); end
    tests++; if (del_cnt_o !== 16'd0 || ins_cnt_o !== 16'd0) begin fails++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", del_cnt_o, ins_cnt_o); end
    tests++; if (dut.u_fifo.level_o !== 4'd0) begin fails++; $display("FAIL reset_level got=%0d exp=0", dut.u_fifo.level_o); end
    reset = 0; ready_i = 0;
  endtask

  task automatic test_stream();
    vec_t exp;
    do_reset();
    ready_i = 1;
    for (int i = 0; i < 22; i++) begin
      if (i == 0) drive_start(sdat(i));
      else if (i == 19) drive_term(sdat(i));
      else if (i < 19) drive_data(sdat(i));
      else drive_none();
      tick();
      exp = (i == 0 || i == 21) ? IDLE_V : stream_v(i - 1);
      tests++; if (out_vec !== exp) begin fails++; $display("FAIL stream[%0d] got=%h exp=%h", i, out_vec, exp); end
    end
    tests++; if (sticky_o !== 2'b00) begin fails++; $display("FAIL stream_sticky got=%b exp=00", sticky_o); end
    ready_i = 0;
  endtask

  task automatic test_insert();
    do_reset();
    ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (out_vec !== IDLE_V) begin fails++; $display("FAIL insert[%0d] got=%h exp=%h", i, out_vec, IDLE_V); end
    end
    ready_i = 0;
    tests++; if (ins_cnt_o !== (STAT ? 16'd3 : 16'd0)) begin fails++; $display("FAIL insert_cnt got=%0d exp=%0d", ins_cnt_o, STAT ? 3 : 0); end
  endtask

  task automatic test_delete();
    do_reset();
    for (int i = 0; i < 7; i++) begin drive_data(64'hD0 + 64'(i)); tick(); end
    tests++; if (dut.u_fifo.level_o !== 4'd7) begin fails++; $display("FAIL del_prefill got=%0d exp=7", dut.u_fifo.level_o); end
    drive_idle(); tick();
    tests++; if (dut.u_fifo.level_o !== 4'd7) begin fails++; $display("FAIL del_level got=%0d exp=7", dut.u_fifo.level_o); end
    tests++; if (del_cnt_o !== (STAT ? 16'd1 : 16'd0)) begin fails++; $display("FAIL del_cnt got=%0d exp=%0d", del_cnt_o, STAT ? 1 : 0); end
    drive_none(); ready_i = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      tests++; if (out_vec !== data_v(64'hD0 + 64'(i))) begin fails++; $display("FAIL del_drain[%0d] got=%h exp=%h", i, out_vec, data_v(64'hD0 + 64'(i))); end
    end
    tick();
    tests++; if (out_vec !== IDLE_V) begin fails++; $display("FAIL del_tail got=%h exp=%h", out_vec, IDLE_V); end
    // Same fill level inside a frame: the idle must be kept.
    do_reset();
    drive_start(64'h5); tick();
    for (int i = 0; i < 5; i++) begin drive_data(64'h60 + 64'(i)); tick(); end
    drive_idle(); tick();
    drive_none();
    tests++; if (dut.u_fifo.level_o !== 4'd7) begin fails++; $display("FAIL keep_level got=%0d exp=7", dut.u_fifo.level_o); end
    tests++; if (del_cnt_o !== 16'd0) begin fails++; $display("FAIL keep_cnt got=%0d exp=0", del_cnt_o); end
  endtask

  task automatic test_underrun();
    do_reset();
    ready_i = 1;
    drive_start(64'h77); tick();
    tests++; if (out_vec !== IDLE_V) begin fails++; $display("FAIL und_first got=%h exp=%h", out_vec, IDLE_V); end
    drive_none(); tick();
    tests++; if (out_vec !== start_v(64'h77)) begin fails++; $display("FAIL und_start got=%h exp=%h", out_vec, start_v(64'h77)); end
    tick();
    tests++; if (out_vec !== ERR_V) begin fails++; $display("FAIL und_err got=%h exp=%h", out_vec, ERR_V); end
    tests++; if (sticky_o !== 2'b10) begin fails++; $display("FAIL und_sticky got=%b exp=10", sticky_o); end
    tick();
    tests++; if (out_vec !== IDLE_V) begin fails++; $display("FAIL und_after got=%h exp=%h", out_vec, IDLE_V); end
    ready_i = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_i = 1;
    drive_data(64'hC0); tick();
    drive_none(); tick();
    tests++; if (out_vec !== data_v(64'hC0)) begin fails++; $display("FAIL ovf_pre got=%h exp=%h", out_vec, data_v(64'hC0)); end
    ready_i = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) drive_data(64'hF00 + 64'(i)); else drive_none();
      tick();
      tests++; if (out_vec !== data_v(64'hC0)) begin fails++; $display("FAIL ovf_hold[%0d] got=%h exp=%h", i, out_vec, data_v(64'hC0)); end
    end
    tests++; if (sticky_o !== 2'b01) begin fails++; $display("FAIL ovf_sticky got=%b exp=01", sticky_o); end
    tests++; if (dut.u_fifo.level_o !== 4'd8) begin fails++; $display("FAIL ovf_level got=%0d exp=8", dut.u_fifo.level_o); end
    // Push onto the full FIFO while it pops: accepted.
    ready_i = 1;
    drive_data(64'hBEEF); tick();
    tests++; if (out_vec !== data_v(64'hF00)) begin fails++; $display("FAIL ovf_pop0 got=%h exp=%h", out_vec, data_v(64'hF00)); end
    tests++; if (dut.u_fifo.level_o !== 4'd8) begin fails++; $display("FAIL ovf_samecyc got=%0d exp=8", dut.u_fifo.level_o); end
    drive_none();
    for (int i = 1; i < 8; i++) begin
      tick();
      tests++; if (out_vec !== data_v(64'hF00 + 64'(i))) begin fails++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, out_vec, data_v(64'hF00 + 64'(i))); end
    end
    tick();
    tests++; if (out_vec !== data_v(64'hBEEF)) begin fails++; $display("FAIL ovf_last got=%h exp=%h", out_vec, data_v(64'hBEEF)); end
    tick();
    tests++; if (out_vec !== IDLE_V) begin fails++; $display("FAIL ovf_tail got=%h exp=%h", out_vec, IDLE_V); end
    ready_i = 0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    drive_start(64'h11); tick();
    for (int i = 0; i < 5; i++) begin drive_data(64'h20 + 64'(i)); tick(); end
    drive_none(); ready_i = 1; tick();
    tests++; if (out_vec !== start_v(64'h11)) begin fails++; $display("FAIL mid_start got=%h exp=%h", out_vec, start_v(64'h11)); end
    tests++; if (dut.u_fifo.level_o !== 4'd5) begin fails++; $display("FAIL mid_level got=%0d exp=5", dut.u_fifo.level_o); end
    reset = 1; tick(); reset = 0;
    tests++; if (out_vec !== IDLE_V) begin fails++; $display("FAIL mid_rst_out got=%h exp=%h", out_vec, IDLE_V); end
    tests++; if (dut.u_fifo.level_o !== 4'd0) begin fails++; $display("FAIL mid_rst_level got=%0d exp=0", dut.u_fifo.level_o); end
    tests++; if (del_cnt_o !== 16'd0 || ins_cnt_o !== 16'd0) begin fails++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", del_cnt_o, ins_cnt_o); end
    tick();
    tests++; if (out_vec !== IDLE_V) begin fails++; $display("FAIL mid_no_err got=%h exp=%h", out_vec, IDLE_V); end
    tests++; if (sticky_o !== 2'b00) begin fails++; $display("FAIL mid_sticky got=%b exp=00", sticky_o); end
    ready_i = 0;
  endtask

  initial begin
    reset = 1; ready_i = 0; drive_none();
    test_reset();
    test_stream();
    test_insert();
    test_delete();
    test_underrun();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
